bus_hub_n: RTL and testbench

BUS_HUB_N -- requirements
Module: bus_hub_n

---
 rtl/bus_hub_n_if.sv | 22 ++
 rtl/bus_hub_n.sv | 130 +++++++++++++
 tb/tb_bus_hub_n.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/bus_hub_n_if.sv
// Host-side request/response bus of the hub: the host is the master,
// the hub is the slave.
interface bus_hub_n_if;
    logic [31:0] host_address;
    logic [31:0] host_data_write;
    logic [3:0]  host_write_mask;
    logic        host_wen;
    logic        host_ren;
    logic [31:0] host_data_read;
    logic        host_ready;
    logic        host_error;

    modport master (
        output host_address, host_data_write, host_write_mask, host_wen, host_ren,
        input  host_data_read, host_ready, host_error
    );

    modport slave (
        input  host_address, host_data_write, host_write_mask, host_wen, host_ren,
        output host_data_read, host_ready, host_error
    );
endinterface

// File: rtl/bus_hub_n.sv
// Single-host to N-device address-decoding hub with per-access timeout.
// One transaction in flight at a time: IDLE -> ACCESS -> RESP -> IDLE.
module bus_hub_n #(
    parameter int                  N_DEV    = 4,
    parameter logic [N_DEV*32-1:0] DEV_BASE = {32'h0003_0000, 32'h0002_0000,
                                               32'h0001_0000, 32'h0000_0000},
    parameter logic [N_DEV*32-1:0] DEV_MASK = {4{32'hFFFF_0000}},
    parameter int                  TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst,
    bus_hub_n_if.slave          host,
    output logic [N_DEV*32-1:0] device_address_o,
    output logic [N_DEV*32-1:0] device_data_write_o,
    output logic [N_DEV*4-1:0]  device_write_mask_o,
    output logic [N_DEV-1:0]    device_wen_o,
    output logic [N_DEV-1:0]    device_ren_o,
    input  logic [N_DEV-1:0]    device_ready_i,
    input  logic [N_DEV*32-1:0] device_data_read_i
);

    localparam int          SEL_W        = (N_DEV > 1) ? $clog2(N_DEV) : 1;
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e             state_q;
    logic [15:0]        cnt_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [3:0]         mask_q;
    logic [SEL_W-1:0]   sel_q;
    logic [N_DEV-1:0]   devWen_q;
    logic [N_DEV-1:0]   devRen_q;
    logic               ready_q;
    logic               error_q;
    logic [31:0]        rdata_q;

    logic               hit_d;
    logic [SEL_W-1:0]   hitIdx_d;
    logic [N_DEV-1:0]   hitOneHot_d;

    // Scan from the top index down so the lowest matching device wins.
    always_comb begin
        hit_d    = 1'b0;
        hitIdx_d = '0;
        for (int i = N_DEV - 1; i >= 0; i--) begin
            if ((host.host_address & DEV_MASK[i*32 +: 32]) == DEV_BASE[i*32 +: 32]) begin
                hit_d    = 1'b1;
                hitIdx_d = SEL_W'(i);
            end
        end
        hitOneHot_d = N_DEV'(1) << hitIdx_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            mask_q   <= '0;
            sel_q    <= '0;
            devWen_q <= '0;
            devRen_q <= '0;
            ready_q  <= 1'b0;
            error_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            ready_q <= 1'b0;
            error_q <= 1'b0;
            rdata_q <= '0;
            case (state_q)
                IDLE: begin
                    if (host.host_wen || host.host_ren) begin
                        addr_q  <= host.host_address;
                        wdata_q <= host.host_data_write;
                        mask_q  <= host.host_write_mask;
                        cnt_q   <= '0;
                        if (hit_d) begin
                            sel_q    <= hitIdx_d;
                            devWen_q <= host.host_wen ? hitOneHot_d : '0;
                            devRen_q <= host.host_wen ? '0 : hitOneHot_d;
                            state_q  <= ACCESS;
                        end else begin
                            ready_q <= 1'b1;
                            error_q <= 1'b1;
                            state_q <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    // Only the selected device's ready counts; reads return its data, writes return 0.
                    if (device_ready_i[sel_q]) begin
                        rdata_q  <= (|devRen_q) ? device_data_read_i[sel_q*32 +: 32] : '0;
                        ready_q  <= 1'b1;
                        devWen_q <= '0;
                        devRen_q <= '0;
                        state_q  <= RESP;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        ready_q  <= 1'b1;
                        error_q  <= 1'b1;
                        devWen_q <= '0;
                        devRen_q <= '0;
                        state_q  <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign host.host_ready     = ready_q;
    assign host.host_error     = error_q;
    assign host.host_data_read = rdata_q;

    assign device_address_o    = {N_DEV{addr_q}};
    assign device_data_write_o = {N_DEV{wdata_q}};
    assign device_write_mask_o = {N_DEV{mask_q}};
    assign device_wen_o        = devWen_q;
    assign device_ren_o        = devRen_q;

endmodule

// File: tb/tb_bus_hub_n.sv
// Directed-vector bench for bus_hub_n: decode, latency, timeout, reset abort,
// read/write collision and ignored non-selected ready.
module tb_bus_hub_n;

    logic         clk;
    logic         rst;
    logic [127:0] devAddr;
    logic [127:0] devWdata;
    logic [15:0]  devMask;
    logic [3:0]   devWen;
    logic [3:0]   devRen;
    logic [3:0]   devReady;
    logic [127:0] devRdata;

    int checkCount;
    int passCount;

    bus_hub_n_if hostBus ();

    bus_hub_n #(.TIMEOUT(8)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .host                (hostBus),
        .device_address_o    (devAddr),
        .device_data_write_o (devWdata),
        .device_write_mask_o (devMask),
        .device_wen_o        (devWen),
        .device_ren_o        (devRen),
        .device_ready_i      (devReady),
        .device_data_read_i  (devRdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    endtask

    task automatic stepCycle;
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single cycle; returns just after the edge that sampled it.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] mask, input logic wen, input logic ren);
        hostBus.host_address    = addr;
        hostBus.host_data_write = wdata;
        hostBus.host_write_mask = mask;
        hostBus.host_wen        = wen;
        hostBus.host_ren        = ren;
        stepCycle();
        hostBus.host_wen = 1'b0;
        hostBus.host_ren = 1'b0;
    endtask

    initial begin
        int wenCycles;
        logic sawReady;

        checkCount = 0;
        passCount  = 0;
        rst        = 1'b1;
        hostBus.host_address    = '0;
        hostBus.host_data_write = '0;
        hostBus.host_write_mask = '0;
        hostBus.host_wen        = 1'b0;
        hostBus.host_ren        = 1'b0;
        devReady = '0;
        devRdata = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'hAAAA_5555};

        stepCycle();
        stepCycle();
        checkOutput("rst_ready", 128'(hostBus.host_ready), 128'd0);
        checkOutput("rst_error", 128'(hostBus.host_error), 128'd0);
        checkOutput("rst_rdata", 128'(hostBus.host_data_read), 128'd0);
        checkOutput("rst_strobes", {120'd0, devWen, devRen}, 128'd0);
        checkOutput("rst_addr", devAddr, 128'd0);
        checkOutput("rst_wdata_mask", devWdata | 128'(devMask), 128'd0);
        rst = 1'b0;

        applyStimulus(32'h0001_0004, 32'h0, 4'h0, 1'b0, 1'b1);
        checkOutput("rd1_ren", 128'(devRen), 128'h2);
        checkOutput("rd1_wen", 128'(devWen), 128'h0);
        checkOutput("rd1_not_ready_yet", 128'(hostBus.host_ready), 128'd0);
        checkOutput("rd1_dev_addr", 128'(devAddr[63:32]), 128'h0001_0004);
        devReady = 4'b0010;
        stepCycle();
        devReady = 4'b0000;
        checkOutput("rd1_ready", 128'(hostBus.host_ready), 128'd1);
        checkOutput("rd1_data", 128'(hostBus.host_data_read), 128'hDEAD_BEEF);
        checkOutput("rd1_error", 128'(hostBus.host_error), 128'd0);
        checkOutput("rd1_ren_off", 128'(devRen), 128'h0);
        stepCycle();
        checkOutput("rd1_ready_pulse", 128'(hostBus.host_ready), 128'd0);
        checkOutput("rd1_data_zero", 128'(hostBus.host_data_read), 128'd0);

        applyStimulus(32'h0000_0010, 32'h1234_5678, 4'b0011, 1'b1, 1'b0);
        checkOutput("wr0_wen_c1", 128'(devWen), 128'h1);
        checkOutput("wr0_addr", 128'(devAddr[31:0]), 128'h0000_0010);
        checkOutput("wr0_wdata", 128'(devWdata[31:0]), 128'h1234_5678);
        checkOutput("wr0_mask", 128'(devMask[3:0]), 128'h3);
        checkOutput("wr0_addr_dev3", 128'(devAddr[127:96]), 128'h0000_0010);
        stepCycle();
        checkOutput("wr0_wen_c2", 128'(devWen), 128'h1);
        checkOutput("wr0_no_ready_c2", 128'(hostBus.host_ready), 128'd0);
        stepCycle();
        checkOutput("wr0_wen_c3", 128'(devWen), 128'h1);
        devReady = 4'b0001;
        stepCycle();
        devReady = 4'b0000;
        checkOutput("wr0_ready", 128'(hostBus.host_ready), 128'd1);
        checkOutput("wr0_error", 128'(hostBus.host_error), 128'd0);
        checkOutput("wr0_data_zero", 128'(hostBus.host_data_read), 128'd0);
        checkOutput("wr0_wen_off", 128'(devWen), 128'h0);
        stepCycle();

        applyStimulus(32'h0009_0000, 32'h0, 4'h0, 1'b0, 1'b1);
        checkOutput("unmap_ready", 128'(hostBus.host_ready), 128'd1);
        checkOutput("unmap_error", 128'(hostBus.host_error), 128'd1);
        checkOutput("unmap_data", 128'(hostBus.host_data_read), 128'd0);
        checkOutput("unmap_strobes", {120'd0, devWen, devRen}, 128'd0);
        stepCycle();
        checkOutput("unmap_ready_pulse", 128'(hostBus.host_ready), 128'd0);

        // Back-to-back with the unmapped access: the hub is in IDLE again here.
        applyStimulus(32'h0002_0040, 32'h5A5A_0000, 4'hF, 1'b1, 1'b0);
        wenCycles = 0;
        sawReady  = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (hostBus.host_ready) begin
                sawReady = 1'b1;
                break;
            end
            if (devWen == 4'b0100) wenCycles++;
            stepCycle();
        end
        checkOutput("to_seen_ready", 128'(sawReady), 128'd1);
        checkOutput("to_wen_cycles", 128'(wenCycles), 128'd8);
        checkOutput("to_error", 128'(hostBus.host_error), 128'd1);
        checkOutput("to_data", 128'(hostBus.host_data_read), 128'd0);
        checkOutput("to_wen_off", 128'(devWen), 128'h0);
        stepCycle();
        checkOutput("to_ready_pulse", 128'(hostBus.host_ready), 128'd0);

        applyStimulus(32'h0003_0008, 32'h0, 4'h0, 1'b0, 1'b1);
        checkOutput("rst3_ren", 128'(devRen), 128'h8);
        stepCycle();
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        checkOutput("rst3_ready", 128'(hostBus.host_ready), 128'd0);
        checkOutput("rst3_strobes", {120'd0, devWen, devRen}, 128'd0);
        checkOutput("rst3_addr", devAddr, 128'd0);
        checkOutput("rst3_error_data", 128'(hostBus.host_error) | 128'(hostBus.host_data_read), 128'd0);
        stepCycle();
        checkOutput("rst3_no_late_ready", 128'(hostBus.host_ready), 128'd0);

        applyStimulus(32'h0003_000C, 32'h0, 4'h0, 1'b0, 1'b1);
        checkOutput("rd3_ren", 128'(devRen), 128'h8);
        devReady = 4'b1000;
        stepCycle();
        devReady = 4'b0000;
        checkOutput("rd3_ready", 128'(hostBus.host_ready), 128'd1);
        checkOutput("rd3_data", 128'(hostBus.host_data_read), 128'h3333_3333);
        checkOutput("rd3_error", 128'(hostBus.host_error), 128'd0);
        stepCycle();

        // Reset wins over a request presented on the same edge.
        hostBus.host_address = 32'h0000_0000;
        hostBus.host_ren     = 1'b1;
        rst                  = 1'b1;
        stepCycle();
        hostBus.host_ren = 1'b0;
        rst              = 1'b0;
        checkOutput("rstreq_strobes", {120'd0, devWen, devRen}, 128'd0);
        stepCycle();
        checkOutput("rstreq_ready", 128'(hostBus.host_ready), 128'd0);

        devReady = 4'b0010;
        applyStimulus(32'h0000_0020, 32'hCAFE_F00D, 4'b1100, 1'b1, 1'b1);
        checkOutput("both_wen", 128'(devWen), 128'h1);
        checkOutput("both_ren", 128'(devRen), 128'h0);
        stepCycle();
        checkOutput("both_ignore_dev1", 128'(hostBus.host_ready), 128'd0);
        checkOutput("both_wen_c2", 128'(devWen), 128'h1);
        devReady = 4'b0011;
        stepCycle();
        devReady = 4'b0000;
        checkOutput("both_ready", 128'(hostBus.host_ready), 128'd1);
        checkOutput("both_error", 128'(hostBus.host_error), 128'd0);
        checkOutput("both_data_zero", 128'(hostBus.host_data_read), 128'd0);
        stepCycle();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
